// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation encodings, FSM state type and iteration constants
// shared by muldiv_unit and its testbench.
package muldiv_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int CNT_WIDTH          = 5;

  // Number of RUN iterations for the default operand width.
  localparam logic [CNT_WIDTH-1:0] ITER_COUNT = 5'd16;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 5'd1;

  localparam logic [1:0] OP_MULL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the divider operations (quotient or remainder).
  function automatic logic is_div_op(input logic [1:0] op_v);
    return (op_v == OP_DIV) || (op_v == OP_REM);
  endfunction

  // True when the result comes from the upper half of the accumulator
  // (product high half, or remainder after a divide).
  function automatic logic takes_high_half(input logic [1:0] op_v);
    return (op_v == OP_MULH) || (op_v == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiplier / divider, one bit per cycle.
// A shared 2W-bit accumulator holds {partial product, multiplier} for MUL and
// {remainder, dividend/quotient} for DIV/REM; the result is the low or high
// half of the final accumulator.
// Optional feature: define MULDIV_DIVIDE_EN to build the divider datapath;
// without it DIV/REM complete in one cycle with result 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [REG_DATA_WIDTH-1:0] a,
  input  logic [REG_DATA_WIDTH-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      div_by_zero
);

  localparam int W = REG_DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(REG_DATA_WIDTH - 1);

  state_e               state_q;
  logic [1:0]           op_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         opnd_q;     // multiplicand for MUL, divisor for DIV/REM
  logic [2*W-1:0]       acc_q;
  logic [2*W-1:0]       acc_d;
  logic [W-1:0]         res_d;
  logic [W:0]           add_sum_s;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [W-1:0]         result_q;
  logic                 instant_s;
  logic [W-1:0]         instant_res_s;
  logic                 instant_dbz_s;
`ifdef MULDIV_DIVIDE_EN
  logic [W:0]           shl_rem_s;
  logic [W:0]           sub_diff_s;
`endif

  // One iteration of shift-add multiply or restoring divide, plus result pick.
  always_comb begin
    add_sum_s = {1'b0, acc_q[2*W-1:W]};
    acc_d     = acc_q;
`ifdef MULDIV_DIVIDE_EN
    shl_rem_s  = {acc_q[2*W-1:W], acc_q[W-1]};
    sub_diff_s = shl_rem_s - {1'b0, opnd_q};
`endif
    if (!is_div_op(op_q)) begin
      if (acc_q[0]) begin
        add_sum_s = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
      end else begin
        add_sum_s = {1'b0, acc_q[2*W-1:W]};
      end
      acc_d = {add_sum_s, acc_q[W-1:1]};
    end else begin
`ifdef MULDIV_DIVIDE_EN
      // A clear borrow bit means the shifted remainder covered the divisor.
      if (!sub_diff_s[W]) begin
        acc_d = {sub_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {shl_rem_s[W-1:0], acc_q[W-2:0], 1'b0};
      end
`else
      acc_d = acc_q;
`endif
    end
    if (takes_high_half(op_q)) begin
      res_d = acc_d[2*W-1:W];
    end else begin
      res_d = acc_d[W-1:0];
    end
  end

  // Decide whether a newly requested op skips RUN, and what it returns if so.
  always_comb begin
`ifdef MULDIV_DIVIDE_EN
    if (is_div_op(op) && (b == {W{1'b0}})) begin
      instant_s     = 1'b1;
      instant_res_s = (op == OP_REM) ? a : {W{1'b1}};
      instant_dbz_s = 1'b1;
    end else begin
      instant_s     = 1'b0;
      instant_res_s = {W{1'b0}};
      instant_dbz_s = 1'b0;
    end
`else
    if (is_div_op(op)) begin
      instant_s     = 1'b1;
      instant_res_s = {W{1'b0}};
      instant_dbz_s = 1'b0;
    end else begin
      instant_s     = 1'b0;
      instant_res_s = {W{1'b0}};
      instant_dbz_s = 1'b0;
    end
`endif
  end

  // Control FSM with operand capture, iteration counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      cnt_q    <= {CNT_WIDTH{1'b0}};
      opnd_q   <= {W{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= {W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q <= op;
            if (instant_s) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= instant_res_s;
              dbz_q    <= instant_dbz_s;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              cnt_q   <= {CNT_WIDTH{1'b0}};
              opnd_q  <= is_div_op(op) ? b : a;
              acc_q   <= is_div_op(op) ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          if (cnt_q == LAST_ITER) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            result_q <= res_d;
            dbz_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (product halves, quotient, remainder).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.REG_DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected result, divide-by-zero flag and start-to-done edges.
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic z, output int lat);
    logic [31:0] p;
    p   = {16'd0, x} * {16'd0, y};
    z   = 1'b0;
    lat = int'(ITER_COUNT) + 1;
    if (o == OP_MULL) r = p[15:0];
    else if (o == OP_MULH) r = p[31:16];
    else begin
`ifdef MULDIV_DIVIDE_EN
      if (y == 16'd0) begin
        r   = (o == OP_DIV) ? 16'hFFFF : x;
        z   = 1'b1;
        lat = 1;
      end else begin
        r = (o == OP_DIV) ? (x / y) : (x % y);
      end
`else
      r   = 16'd0;
      lat = 1;
`endif
    end
  endfunction

  // Issue one op, scramble operands afterwards, optionally pulse start mid-RUN.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input int glitch_at);
    logic [15:0] er;
    logic [15:0] held;
    logic        ez;
    logic        bad;
    int          el;
    int          lat;
    model(o, x, y, er, ez, el);
    @(negedge clk);
    held = result;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    bad = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || result !== held) bad = 1'b1;
      if (lat == glitch_at) begin
        start = 1'b1; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom) | 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
    check({tag, " busy/hold"}, 32'(bad | busy), 32'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " result hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic got_done;
    logic bad;
    int   last;
    int   n;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 16'd0; b = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mull", OP_MULL, 16'h1234, 16'h0010, -1);
    run_op("mulh", OP_MULH, 16'h1234, 16'h0010, -1);
    run_op("div", OP_DIV, 16'd100, 16'd7, -1);
    run_op("rem", OP_REM, 16'd100, 16'd7, -1);
    run_op("div0", OP_DIV, 16'h0055, 16'h0000, -1);
    run_op("rem0", OP_REM, 16'h0055, 16'h0000, -1);
    run_op("ignore start in run", OP_MULL, 16'hBEEF, 16'h0123, 5);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ry;
      ry = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      run_op("random", 2'($urandom_range(0, 3)), 16'($urandom), ry, -1);
    end

    // Abort an operation with reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; op = OP_MULH; a = 16'hF00D; b = 16'hCAFE;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort dbz", 32'(div_by_zero), 32'd0);
    got_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) got_done = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) got_done = 1'b1;
    end
    check("no done after abort", 32'(got_done), 32'd0);
    run_op("after reset", OP_MULL, 16'h00FF, 16'h0101, -1);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; op = OP_MULH; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    last = -1; n = 0; bad = 1'b0;
    for (int e = 0; e < 60; e++) begin
      if (busy === 1'b1 && done === 1'b1) bad = 1'b1;
      if (done === 1'b1) begin
        if (n == 0) check("b2b first done", 32'(e), 32'd16);
        else check("b2b interval", 32'(e - last), 32'd17);
        check("b2b result", 32'(result), 32'h0000FFFE);
        last = e;
        n++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b done count", 32'(n), 32'd3);
    check("b2b busy&done", 32'(bad), 32'd0);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
